// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: read handshake between the refill controller and next-level instruction memory
interface icache_refill_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss detection, 4-beat line refill and fill strobe for the instruction cache
module icache_refill_ctrl #(
  parameter int TAG_W = 27,
  parameter int SET_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [31:0]          pc,
  input  logic                 hit,
  input  logic [1:0]           victim_way,
  output logic                 stall,
  icache_refill_ctrl_if.master mem,
  output logic                 fill_en,
  output logic [SET_W-1:0]     fill_set,
  output logic [1:0]           fill_way,
  output logic [TAG_W-1:0]     fill_tag,
  output logic [127:0]         fill_data,
  output logic [CNT_W-1:0]     miss_count
);
  typedef enum logic [1:0] {IDLE, REQ, FILL, REPLAY} state_t;
  state_t state, state_nx;
  logic [29:0] base;
  logic [1:0] beat;
  logic miss, last_beat, unused;
  assign miss = fetch_valid & ~hit;
  assign last_beat = mem.mem_ack & (beat == 2'd3);
  assign unused = ^pc[1:0];
  assign mem.mem_addr = {base, beat};
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state, stall and strobes
  always_comb begin
    state_nx = state == IDLE ? (miss ? REQ : IDLE) :
               state == REQ ? (last_beat ? FILL : REQ) :
               state == FILL ? REPLAY : IDLE;
    stall = state == IDLE ? miss : 1'b1;
    mem.mem_req = state == REQ;
    fill_en = state == FILL;
  end
  // latch miss context, assemble the line beat by beat, count misses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base <= '0;
      beat <= '0;
      fill_set <= '0;
      fill_way <= '0;
      fill_tag <= '0;
      fill_data <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && miss) begin
        base <= pc[31:2];
        beat <= '0;
        fill_set <= pc[2 +: SET_W];
        fill_tag <= pc[2+SET_W +: TAG_W];
        fill_way <= victim_way;
        miss_count <= &miss_count ? miss_count : miss_count + 1'b1;
      end
      if (state == REQ && mem.mem_ack) begin
        fill_data[{beat, 5'd0} +: 32] <= mem.mem_rdata;
        beat <= beat + 1'b1;
      end
    end
  end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-handling and refill controller for the 8-set, 4-way instruction cache with 128-bit lines.
- Sits between the fetch-stage cache lookup and next-level instruction memory.
- On a lookup miss it stalls fetch and reads the aligned 4-word line through a req/ack handshake.
- It assembles the 128-bit line, writes line, tag and valid into the chosen victim way, then replays the lookup.

Parameters:
- TAG_W, 27, tag width (pc[31:5])
- SET_W, 3, set index width (pc[4:2])
- CNT_W, 16, miss counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch stage presents a valid pc this cycle
- pc  in  32  word address: tag pc[31:5], set pc[4:2], word pc[1:0]
- hit  in  1  cache lookup hit for current pc (combinational from cache)
- victim_way  in  2  LRU way of the indexed set, from cache
- stall  out  1  freeze PC/fetch
- mem_req  out  1  read request to next-level memory
- mem_addr  out  32  word address of requested beat
- mem_ack  in  1  beat accepted; mem_rdata valid in same cycle
- mem_rdata  in  32  returned instruction word
- fill_en  out  1  one-cycle write strobe to cache
- fill_set  out  SET_W  set to write
- fill_way  out  2  way to write
- fill_tag  out  TAG_W  tag to write; valid bit set by cache on fill_en
- fill_data  out  128  line; word k at bits [32k+31:32k]
- miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE; stall, mem_req, fill_en = 0.
  - mem_addr, fill_set, fill_way, fill_tag, fill_data, miss_count = 0.
  - The beat counter and latched pc/way are cleared.
  - Reset mid-burst abandons the burst; no fill is issued.
- States: IDLE, REQ, FILL, REPLAY.
- IDLE:
  - stall = fetch_valid & ~hit (combinational).
  - On an edge with fetch_valid & ~hit:
    - latch tag=pc[31:5], set=pc[4:2], way=victim_way;
    - beat=0; mem_addr={pc[31:2],2'b00}; mem_req=1;
    - miss_count+=1, saturating at all-ones;
    - next state REQ.
  - mem_ack in IDLE is ignored.
- REQ:
  - stall=1; mem_req=1; mem_addr held stable until an edge samples mem_ack=1.
  - On ack: store mem_rdata into fill_data word[beat]; beat+=1; mem_addr low 2 bits = beat+1.
  - Beats are always issued in order 0,1,2,3, starting at the aligned line base regardless of pc[1:0].
  - After the ack of beat 3: mem_req=0 on the following cycle; next state FILL.
  - No timeout; REQ waits indefinitely for ack.
- FILL:
  - stall=1; fill_en=1 for exactly one cycle.
  - fill_set, fill_way and fill_tag take the latched values; fill_data holds the full line.
  - Next state REPLAY.
- REPLAY:
  - stall=1; fill_en=0; one cycle so the cache (negedge-updated) presents the new line.
  - Next state IDLE; the same pc is re-looked-up and must hit.
- pc, hit and victim_way changes during REQ/FILL/REPLAY are ignored; only latched values are used.
- Latency: a miss with zero-wait memory (ack every cycle) stalls 1 (detect) + 4 (beats) + 1 (FILL) + 1 (REPLAY) = 7 cycles before the hit cycle.
- fill_data, fill_set, fill_way and fill_tag hold their last values outside FILL; consumers qualify with fill_en.
- A back-to-back miss in IDLE directly after REPLAY starts a new refill without an idle gap.

Test Plan:
- Reset mid-operation:
  - Stimulus: hold reset=0, release; assert reset=0 during REQ after beat 1.
  - Response: all outputs 0, state IDLE, no fill_en ever pulses.
- Zero-wait miss:
  - Stimulus: pc=0x0000_0047 (tag 0x2, set 1, word 3), hit=0, victim_way=2; mem_ack=1 every cycle; memory returns word address.
  - Response: mem_addr 0x44, 0x45, 0x46, 0x47; fill_en once with set=1, way=2, tag=0x2, fill_data={0x47,0x46,0x45,0x44}; stall high exactly 7 cycles; miss_count=1.
- Wait states:
  - Stimulus: mem_ack delayed 3 cycles per beat.
  - Response: mem_addr stable while unacked; fill_data identical to the zero-wait case; stall extends by 12 cycles.
- Input churn during miss:
  - Stimulus: pc and victim_way toggle during REQ.
  - Response: fill uses the values latched at miss detection.
- Hit path:
  - Stimulus: fetch_valid=1, hit=1 for 10 cycles.
  - Response: stall=0, mem_req=0, miss_count unchanged.
- Counter saturation:
  - Stimulus: CNT_W=2, 5 consecutive misses.
  - Response: miss_count sequence 1, 2, 3, 3, 3.
